// File: rtl/apb_modport_pkg.sv
// Shared constants and FSM encoding for the two-slave APB subsystem.
package apb_modport_pkg;
    localparam int ADDR_WIDTH = 9;
    localparam int DATA_WIDTH = 8;
    localparam int OFFS_WIDTH = ADDR_WIDTH - 1;
    localparam int MEM_DEPTH  = 2 ** OFFS_WIDTH;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;
endpackage

// File: rtl/apb_modport_if.sv
// User-side request bundle: the requester drives through master, the APB subsystem listens through slave.
interface apb_modport_if
    import apb_modport_pkg::*;
();
    logic                  transfer;
    logic                  READ_WRITE;
    logic [ADDR_WIDTH-1:0] apb_write_paddr;
    logic [ADDR_WIDTH-1:0] apb_read_paddr;
    logic [DATA_WIDTH-1:0] apb_write_data;
    logic [DATA_WIDTH-1:0] apb_read_data_out;

    modport master (
        output transfer, READ_WRITE, apb_write_paddr, apb_read_paddr, apb_write_data,
        input  apb_read_data_out
    );

    modport slave (
        input  transfer, READ_WRITE, apb_write_paddr, apb_read_paddr, apb_write_data,
        output apb_read_data_out
    );
endinterface

// File: rtl/apb_slave.sv
// Zero-wait-state APB memory slave; contents clear to zero on reset.
module apb_slave
    import apb_modport_pkg::*;
(
    input  logic                  pclk,
    input  logic                  presetn,
    input  logic                  psel,
    input  logic                  penable,
    input  logic                  pwrite,
    input  logic [OFFS_WIDTH-1:0] paddr,
    input  logic [DATA_WIDTH-1:0] pwdata,
    output logic [DATA_WIDTH-1:0] prdata,
    output logic                  pready
);
    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    // Ready asserts in the first ACCESS cycle, so every transfer completes without wait states.
    assign pready = psel & penable;
    assign prdata = (psel && !pwrite) ? mem[paddr] : '0;

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            for (int i = 0; i < MEM_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (psel && penable && pwrite && pready) begin
            mem[paddr] <= pwdata;
        end
    end
endmodule

// File: rtl/apb_modport.sv
// APB master FSM driving two memory slaves; address MSB picks the slave.
module apb_modport
    import apb_modport_pkg::*;
(
    input  logic          pclk,
    input  logic          presetn,
    apb_modport_if.slave  user
);
    state_t                state_q, state_d;
    logic                  pwrite;
    logic [ADDR_WIDTH-1:0] paddr;
    logic [DATA_WIDTH-1:0] pwdata;
    logic [DATA_WIDTH-1:0] read_data;
    logic                  psel1, psel2, penable;
    logic                  pready, pready0, pready1;
    logic [DATA_WIDTH-1:0] prdata, prdata0, prdata1;
    logic                  load, done;

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        done    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (user.transfer) begin
                    state_d = SETUP;
                    load    = 1'b1;
                end
            end
            SETUP: state_d = ACCESS;
            ACCESS: begin
                if (pready) begin
                    done = 1'b1;
                    // A held request chains straight into the next SETUP.
                    if (user.transfer) begin
                        state_d = SETUP;
                        load    = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state_q   <= IDLE;
            pwrite    <= 1'b0;
            paddr     <= '0;
            pwdata    <= '0;
            read_data <= '0;
        end else begin
            state_q <= state_d;
            if (done && !pwrite) begin
                read_data <= prdata;
            end
            if (load) begin
                pwrite <= ~user.READ_WRITE;
                paddr  <= user.READ_WRITE ? user.apb_read_paddr : user.apb_write_paddr;
                pwdata <= user.apb_write_data;
            end
        end
    end

    assign psel1   = (state_q != IDLE) && !paddr[ADDR_WIDTH-1];
    assign psel2   = (state_q != IDLE) &&  paddr[ADDR_WIDTH-1];
    assign penable = (state_q == ACCESS);
    assign prdata  = paddr[ADDR_WIDTH-1] ? prdata1 : prdata0;
    assign pready  = paddr[ADDR_WIDTH-1] ? pready1 : pready0;

    assign user.apb_read_data_out = read_data;

    apb_slave u_slave0 (
        .pclk    (pclk),
        .presetn (presetn),
        .psel    (psel1),
        .penable (penable),
        .pwrite  (pwrite),
        .paddr   (paddr[OFFS_WIDTH-1:0]),
        .pwdata  (pwdata),
        .prdata  (prdata0),
        .pready  (pready0)
    );

    apb_slave u_slave1 (
        .pclk    (pclk),
        .presetn (presetn),
        .psel    (psel2),
        .penable (penable),
        .pwrite  (pwrite),
        .paddr   (paddr[OFFS_WIDTH-1:0]),
        .pwdata  (pwdata),
        .prdata  (prdata1),
        .pready  (pready1)
    );
endmodule

// File: tb/tb_apb_modport.sv
// Scoreboard bench for apb_modport: reference memory, expected read data queued with its completion cycle.
module tb_apb_modport;
    import apb_modport_pkg::*;

    logic pclk;
    logic presetn;

    apb_modport_if bus ();

    apb_modport dut (
        .pclk    (pclk),
        .presetn (presetn),
        .user    (bus)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    typedef struct {
        int unsigned     cyc;
        logic [7:0]      val;
    } exp_t;

    exp_t        sb_q[$];
    logic [7:0]  ref_mem [512];
    logic [7:0]  exp_dout;
    int unsigned cyc;
    int          n_checks;
    int          n_fail;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Advance one clock, then compare the read-data output against the scoreboard.
    task automatic tick();
        @(posedge pclk);
        cyc++;
        #2;
        if (sb_q.size() > 0 && sb_q[0].cyc == cyc) begin
            exp_dout = sb_q[0].val;
            void'(sb_q.pop_front());
        end
        check_eq("rdata", 32'(bus.apb_read_data_out), 32'(exp_dout));
    endtask

    task automatic scramble();
        bus.apb_write_paddr = 9'($urandom);
        bus.apb_read_paddr  = 9'($urandom);
        bus.apb_write_data  = 8'($urandom);
        bus.READ_WRITE      = 1'($urandom);
    endtask

    task automatic issue(input bit rd, input logic [8:0] addr, input logic [7:0] data, input bit hold);
        bus.transfer   = 1'b1;
        bus.READ_WRITE = rd;
        if (rd) begin
            bus.apb_read_paddr  = addr;
            bus.apb_write_paddr = 9'($urandom);
            bus.apb_write_data  = 8'($urandom);
            sb_q.push_back('{cyc + 3, ref_mem[addr]});
        end else begin
            bus.apb_write_paddr = addr;
            bus.apb_read_paddr  = 9'($urandom);
            bus.apb_write_data  = data;
            ref_mem[addr]       = data;
        end
        tick();
        check_eq("state_setup", 32'(dut.state_q), 32'(SETUP));
        scramble();
        tick();
        check_eq("state_access", 32'(dut.state_q), 32'(ACCESS));
        if (!hold) begin
            bus.transfer = 1'b0;
            scramble();
            tick();
            check_eq("state_idle", 32'(dut.state_q), 32'(IDLE));
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        cyc      = 0;
        exp_dout = 8'h00;
        for (int i = 0; i < 512; i++) ref_mem[i] = 8'h00;
        presetn             = 1'b0;
        bus.transfer        = 1'b0;
        bus.READ_WRITE      = 1'b0;
        bus.apb_write_paddr = '0;
        bus.apb_read_paddr  = '0;
        bus.apb_write_data  = '0;

        repeat (3) tick();
        check_eq("reset_state", 32'(dut.state_q), 32'(IDLE));
        presetn = 1'b1;
        tick();

        // Reads of freshly cleared memory
        issue(1'b1, 9'h005, 8'h00, 1'b0);
        issue(1'b1, 9'h1FF, 8'h00, 1'b0);

        // Write then read back
        issue(1'b0, 9'h005, 8'hA5, 1'b0);
        issue(1'b1, 9'h005, 8'h00, 1'b0);

        // Slave isolation on the same offset
        issue(1'b0, 9'h105, 8'h3C, 1'b0);
        issue(1'b0, 9'h005, 8'hA5, 1'b0);
        issue(1'b1, 9'h105, 8'h00, 1'b0);
        issue(1'b1, 9'h005, 8'h00, 1'b0);

        // Back-to-back with transfer held high
        issue(1'b0, 9'h0FF, 8'h11, 1'b1);
        issue(1'b1, 9'h0FF, 8'h00, 1'b1);
        issue(1'b0, 9'h1FF, 8'h22, 1'b1);
        issue(1'b1, 9'h1FF, 8'h00, 1'b0);

        // Read data holds across writes and idle time
        issue(1'b1, 9'h0FF, 8'h00, 1'b0);
        issue(1'b0, 9'h020, 8'h99, 1'b0);
        issue(1'b0, 9'h120, 8'h98, 1'b1);
        issue(1'b0, 9'h0FF, 8'h55, 1'b0);
        repeat (5) tick();
        check_eq("hold_value", 32'(bus.apb_read_data_out), 32'h11);
        issue(1'b1, 9'h020, 8'h00, 1'b0);
        issue(1'b1, 9'h0FF, 8'h00, 1'b0);

        // Reset asserted during the ACCESS phase of a write
        bus.transfer        = 1'b1;
        bus.READ_WRITE      = 1'b0;
        bus.apb_write_paddr = 9'h010;
        bus.apb_write_data  = 8'h77;
        tick();
        bus.transfer = 1'b0;
        tick();
        check_eq("pre_reset_access", 32'(dut.state_q), 32'(ACCESS));
        presetn = 1'b0;
        #1;
        sb_q.delete();
        exp_dout = 8'h00;
        for (int i = 0; i < 512; i++) ref_mem[i] = 8'h00;
        check_eq("abort_state", 32'(dut.state_q), 32'(IDLE));
        check_eq("abort_dout", 32'(bus.apb_read_data_out), 32'h00);
        repeat (2) tick();
        check_eq("abort_mem", 32'(dut.u_slave0.mem[16]), 32'h00);
        presetn = 1'b1;
        tick();
        issue(1'b1, 9'h010, 8'h00, 1'b0);
        issue(1'b1, 9'h0FF, 8'h00, 1'b0);

        // Random mix, some chained, finishing with an idle-terminated transfer
        for (int i = 0; i < 40; i++) begin
            logic [8:0] a;
            a = 9'($urandom_range(0, 511));
            if (i % 8 == 0) a = 9'h005;
            issue(1'($urandom), a, 8'($urandom), (i != 39) ? 1'($urandom) : 1'b0);
        end
        repeat (3) tick();
        check_eq("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/apb_modport.md
Name: apb_modport

Overview:
- Self-contained APB subsystem: one APB master FSM driving two APB memory slaves over an internal APB bus.
- The user side issues a read or a write with `transfer` and `READ_WRITE`. The master runs the SETUP/ACCESS protocol.
- Address bit 8 selects slave 0 or slave 1. Read data is returned on `apb_read_data_out`.
- Top-level DUT of the two-slave APB environment.

Parameters:
- ADDR_WIDTH, 9, user address width; MSB is the slave select, low 8 bits are the in-slave offset.
- DATA_WIDTH, 8, data width.
- MEM_DEPTH, 256, bytes per slave (2**(ADDR_WIDTH-1)).

Ports:
- pclk  input  1  system clock; all logic on rising edge.
- presetn  input  1  asynchronous active-low reset.
- transfer  input  1  request a transaction; sampled on pclk.
- READ_WRITE  input  1  1 = read, 0 = write.
- apb_write_paddr  input  9  write address; [8] = slave select.
- apb_read_paddr  input  9  read address; [8] = slave select.
- apb_write_data  input  8  write data.
- apb_read_data_out  output  8  last completed read data.

Behaviour:
- Reset (presetn=0, asynchronous):
  - FSM goes to IDLE.
  - psel1=psel2=penable=pwrite=0; paddr=0; pwdata=0.
  - apb_read_data_out=0.
  - Both slave memories clear to 0x00.
  - Reset has priority over everything. Assertion mid-transfer aborts the transfer: no memory write commits, no read data updates.
- FSM states: IDLE, SETUP, ACCESS (shared enum).
- IDLE:
  - All selects and penable are 0.
  - If transfer=1 at a rising edge, go to SETUP.
  - At that same edge, latch:
    - pwrite = ~READ_WRITE.
    - paddr = READ_WRITE ? apb_read_paddr : apb_write_paddr.
    - pwdata = apb_write_data.
- SETUP (one cycle):
  - psel1 = ~paddr[8]; psel2 = paddr[8].
  - penable=0.
  - Unconditionally go to ACCESS.
- ACCESS:
  - penable=1; psel held.
  - Slaves respond with pready=1 in the same cycle (zero wait states).
  - The master stays in ACCESS while pready=0. The slaves never stall, but the master must honour pready.
  - On the edge ending ACCESS with pready=1:
    - Write: the slave stores pwdata at mem[paddr[7:0]].
    - Read: master registers the slave's prdata into apb_read_data_out.
    - Next state: if transfer=1, go to SETUP with new operands latched (back-to-back, no IDLE cycle); otherwise go to IDLE.
- Latency: transfer sampled at edge E0 → SETUP during E0–E1 → ACCESS during E1–E2 → apb_read_data_out valid after E2. That is 2 cycles, one transfer per 2 cycles sustained.
- apb_read_data_out holds its value across writes and idle periods; it changes only on read completion or reset.
- Slave read data:
  - prdata = mem[paddr[7:0]], combinational while psel&&!pwrite.
  - Otherwise prdata is 0x00.
  - The master muxes prdata by paddr[8].
- Input changes while in SETUP or ACCESS have no effect on the current transfer, because operands are latched.
- Offset wrap: 0x0FF and 0x1FF are the last locations. There is no out-of-range case.
- pslverr is not implemented (always 0 inside).
- A read of a location written in the immediately preceding transfer returns the new value.

Decomposition:
- Package apb_modport_pkg:
  - state_t enum {IDLE, SETUP, ACCESS}.
  - ADDR_WIDTH, DATA_WIDTH, MEM_DEPTH constants.
- Sub-module apb_slave:
  - Ports: pclk, presetn, psel, penable, pwrite, paddr[7:0], pwdata, prdata, pready.
  - Contains the MEM_DEPTH×8 memory.
- Top apb_modport:
  - Contains the master FSM.
  - Instantiates apb_slave twice (u_slave0, u_slave1).

Test Plan:
- Reset then read 0x005 and 0x1FF → apb_read_data_out=0x00 both; output 0x00 during reset.
- Write 0xA5 to 0x005, then read 0x005 → 0xA5 appears 2 cycles after the read's transfer is sampled.
- Slave isolation: write 0x3C to 0x105 and 0xA5 to 0x005; read 0x105 → 0x3C; read 0x005 → 0xA5.
- Back-to-back with transfer held 1: write 0x11@0x0FF, read 0x0FF, write 0x22@0x1FF, read 0x1FF → reads 0x11 then 0x22; no IDLE cycles between; each transfer takes 2 cycles.
- Read data hold: after reading 0x11, perform writes and idle cycles → output stays 0x11 until the next read.
- Reset mid-ACCESS of a write of 0x77@0x010 → FSM IDLE; subsequent read of 0x010 → 0x00; output 0x00.
